pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the five-stage CPU, the successor to the fixed-width stage latches. It carries LANES payload words of WIDTH bits plus a per-entry exception flag. Transfers use a valid/ready handshake with a two-entry skid buffer, so downstream backpressure never reaches upstream combinationally. A synchronous flush converts the stage contents into bubbles, which present as NOP (all-zero) words.

---
 rtl/pipe_stage_reg.sv | 156 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register with a
// valid/ready handshake and a two-entry skid buffer (main = head, skid =
// younger entry). in_ready depends only on registered state, so downstream
// backpressure never reaches upstream combinationally. A synchronous flush
// turns the stage contents into all-zero bubbles.
//
// Optional feature: define PIPE_STAGE_STATS_EN to add the saturating
// stall_cnt / bubble_cnt performance counters and their ports.

module pipe_stage_reg #(
    parameter int WIDTH = 32,
    parameter int LANES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   in_exc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic                   out_exc,
    input  logic                   flush
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]            stall_cnt,
    output logic [31:0]            bubble_cnt
`endif
);

    localparam int DW = LANES * WIDTH;

    // Occupancy is encoded directly by {main_valid, skid_valid}
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic          main_valid, skid_valid;
    logic          main_exc, skid_exc;
    logic [DW-1:0] main_data, skid_data;

    logic          main_valid_nxt, skid_valid_nxt;
    logic          main_exc_nxt, skid_exc_nxt;
    logic [DW-1:0] main_data_nxt, skid_data_nxt;

    logic [1:0]    state;
    logic          acc, emit;

    assign state     = {main_valid, skid_valid};
    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign acc       = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    // Bubbles present as NOP: the head is masked to zero while invalid
    assign out_data  = {DW{main_valid}} & main_data;
    assign out_exc   = main_valid & main_exc;

    // Next-state selection for the head and skid entries; flush wins over
    // any same-cycle accept, and a same-cycle emit needs no extra action
    always_comb begin
        main_valid_nxt = main_valid;
        main_data_nxt  = main_data;
        main_exc_nxt   = main_exc;
        skid_valid_nxt = skid_valid;
        skid_data_nxt  = skid_data;
        skid_exc_nxt   = skid_exc;

        if (flush) begin
            main_valid_nxt = 1'b0;
            main_data_nxt  = '0;
            main_exc_nxt   = 1'b0;
            skid_valid_nxt = 1'b0;
            skid_data_nxt  = '0;
            skid_exc_nxt   = 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (acc) begin
                        main_valid_nxt = 1'b1;
                        main_data_nxt  = in_data;
                        main_exc_nxt   = in_exc;
                    end
                end
                ST_ONE: begin
                    if (acc && emit) begin
                        main_data_nxt  = in_data;
                        main_exc_nxt   = in_exc;
                    end else if (acc) begin
                        skid_valid_nxt = 1'b1;
                        skid_data_nxt  = in_data;
                        skid_exc_nxt   = in_exc;
                    end else if (emit) begin
                        main_valid_nxt = 1'b0;
                        main_data_nxt  = '0;
                        main_exc_nxt   = 1'b0;
                    end
                end
                ST_FULL: begin
                    if (emit) begin
                        main_data_nxt  = skid_data;
                        main_exc_nxt   = skid_exc;
                        skid_valid_nxt = 1'b0;
                        skid_data_nxt  = '0;
                        skid_exc_nxt   = 1'b0;
                    end
                end
                default: begin
                    // Skid-only occupancy cannot arise; fall back to empty
                    main_valid_nxt = 1'b0;
                    main_data_nxt  = '0;
                    main_exc_nxt   = 1'b0;
                    skid_valid_nxt = 1'b0;
                    skid_data_nxt  = '0;
                    skid_exc_nxt   = 1'b0;
                end
            endcase
        end
    end

    // Entry storage with asynchronous clear of every valid, exc and payload bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_exc   <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_exc   <= 1'b0;
        end else begin
            main_valid <= main_valid_nxt;
            main_data  <= main_data_nxt;
            main_exc   <= main_exc_nxt;
            skid_valid <= skid_valid_nxt;
            skid_data  <= skid_data_nxt;
            skid_exc   <= skid_exc_nxt;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    // Saturating backpressure / starvation counters, untouched by flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF))
                stall_cnt <= stall_cnt + 32'd1;
            if (!out_valid && out_ready && (bubble_cnt != 32'hFFFF_FFFF))
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed vector table, hand-written corner sequences
// and a randomized run compared against a queue-based reference model.
// Build with PIPE_STAGE_STATS_EN defined to include the counter checks.

module tb_pipe_stage_reg;

    localparam int WIDTH = 32;
    localparam int LANES = 3;
    localparam int DW    = WIDTH * LANES;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_exc;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_exc;
    logic          flush;
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   bubble_cnt;
`endif

    int n_checks;
    int n_fail;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] lane0;
        logic        exc;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_lane0;
        logic        e_exc;
    } vec_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          e;
    } ent_t;

    vec_t vecs[24];
    ent_t model_q[$];

    pipe_stage_reg #(.WIDTH(WIDTH), .LANES(LANES)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_exc    (in_exc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_exc   (out_exc),
        .flush     (flush)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang
    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    // Every lane carries a distinct, recognisable word derived from lane 0
    function automatic logic [DW-1:0] pack(input logic [31:0] l0);
        return {l0 ^ 32'h2000_0000, l0 ^ 32'h1000_0000, l0};
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic iv, input logic ordy, input logic fl,
                                  input logic [DW-1:0] d, input logic exc);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_data   = d;
        in_exc    = exc;
    endtask

    task automatic check_output(input string tag, input logic e_ir, input logic e_ov,
                                input logic [DW-1:0] e_data, input logic e_exc);
        check_bit ({tag, " in_ready"},  in_ready,  e_ir);
        check_bit ({tag, " out_valid"}, out_valid, e_ov);
        check_data({tag, " out_data"},  out_data,  e_data);
        check_bit ({tag, " out_exc"},   out_exc,   e_exc);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Expected values are the outputs seen during the row, before its edge
        // Pass-through, out_ready=1
        vecs[0]  = '{H, H, L, 32'h1,  L, H, L, 32'h0,  L};
        vecs[1]  = '{H, H, L, 32'h2,  L, H, H, 32'h1,  L};
        vecs[2]  = '{H, H, L, 32'h3,  L, H, H, 32'h2,  L};
        vecs[3]  = '{H, H, L, 32'h4,  L, H, H, 32'h3,  L};
        vecs[4]  = '{L, H, L, 32'h0,  L, H, H, 32'h4,  L};
        vecs[5]  = '{L, H, L, 32'h0,  L, H, L, 32'h0,  L};
        // Backpressure fill: A, B buffered, C held upstream, then drain
        vecs[6]  = '{H, L, L, 32'hA,  L, H, L, 32'h0,  L};
        vecs[7]  = '{H, L, L, 32'hB,  L, H, H, 32'hA,  L};
        vecs[8]  = '{H, L, L, 32'hC,  L, L, H, 32'hA,  L};
        vecs[9]  = '{H, H, L, 32'hC,  L, L, H, 32'hA,  L};
        vecs[10] = '{H, H, L, 32'hC,  L, H, H, 32'hB,  L};
        vecs[11] = '{L, H, L, 32'h0,  L, H, H, 32'hC,  L};
        vecs[12] = '{L, L, L, 32'h0,  L, H, L, 32'h0,  L};
        // Flush while FULL with a same-cycle offer
        vecs[13] = '{H, L, L, 32'h11, L, H, L, 32'h0,  L};
        vecs[14] = '{H, L, L, 32'h22, L, H, H, 32'h11, L};
        vecs[15] = '{H, L, H, 32'h33, L, L, H, 32'h11, L};
        vecs[16] = '{L, H, L, 32'h0,  L, H, L, 32'h0,  L};
        vecs[17] = '{L, H, L, 32'h0,  L, H, L, 32'h0,  L};
        // Exception tagging: X (exc=1) then Y (exc=0), alternating out_ready
        vecs[18] = '{H, H, L, 32'h55, H, H, L, 32'h0,  L};
        vecs[19] = '{H, L, L, 32'h66, L, H, H, 32'h55, H};
        vecs[20] = '{L, H, L, 32'h0,  L, L, H, 32'h55, H};
        vecs[21] = '{L, L, L, 32'h0,  L, H, H, 32'h66, L};
        vecs[22] = '{L, H, L, 32'h0,  L, H, H, 32'h66, L};
        vecs[23] = '{L, L, L, 32'h0,  L, H, L, 32'h0,  L};

        reset = 1'b1;
        apply_stimulus(L, L, L, '0, L);
        repeat (2) @(posedge clk);
        #1;
        check_output("reset", H, L, '0, L);
`ifdef PIPE_STAGE_STATS_EN
        check_word("reset stall_cnt",  stall_cnt,  32'd0);
        check_word("reset bubble_cnt", bubble_cnt, 32'd0);
`endif
        reset = 1'b0;
        apply_stimulus(L, L, L, '0, L);
        next_cycle();

        // Directed vector table
        for (int i = 0; i < 24; i++) begin
            apply_stimulus(vecs[i].iv, vecs[i].ordy, vecs[i].fl, pack(vecs[i].lane0), vecs[i].exc);
            check_output($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov,
                         vecs[i].e_ov ? pack(vecs[i].e_lane0) : '0, vecs[i].e_exc);
            next_cycle();
        end

        // Asynchronous reset between edges while FULL
        apply_stimulus(H, L, L, pack(32'hAA), H);
        next_cycle();
        apply_stimulus(H, L, L, pack(32'hBB), L);
        next_cycle();
        apply_stimulus(L, L, L, '0, L);
        check_output("full before reset", L, H, pack(32'hAA), H);
        #2;
        reset = 1'b1;
        #1;
        check_output("async reset", H, L, '0, L);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // Flush in ONE with same-cycle accept and emit: emit completes, input dropped
        apply_stimulus(H, L, L, pack(32'h77), L);
        next_cycle();
        apply_stimulus(H, H, H, pack(32'h88), L);
        check_output("flush one pre", H, H, pack(32'h77), L);
        next_cycle();
        apply_stimulus(L, H, L, '0, L);
        check_output("flush one post", H, L, '0, L);
        next_cycle();
        check_output("flush one idle", H, L, '0, L);

        // Randomized run against a queue model of a two-entry FIFO
        model_q.delete();
        for (int c = 0; c < 400; c++) begin
            logic          iv, ordy, fl, ex, m_ir, m_ov, acc, emit;
            logic [DW-1:0] d;
            iv   = ($urandom_range(3) != 0);
            ordy = ($urandom_range(9) < 6);
            fl   = ($urandom_range(15) == 0);
            ex   = ($urandom_range(3) == 0);
            d    = {$urandom, $urandom, $urandom};
            apply_stimulus(iv, ordy, fl, d, ex);
            m_ir = (model_q.size() < 2);
            m_ov = (model_q.size() > 0);
            check_output($sformatf("rand%0d", c), m_ir, m_ov,
                         m_ov ? model_q[0].d : '0, m_ov ? model_q[0].e : L);
            acc  = iv && m_ir;
            emit = m_ov && ordy;
            next_cycle();
            if (fl) begin
                model_q.delete();
            end else begin
                if (emit) void'(model_q.pop_front());
                if (acc) model_q.push_back('{d, ex});
            end
        end

`ifdef PIPE_STAGE_STATS_EN
        // Counter check: 5 stalled cycles, 3 starved cycles, then a flush
        reset = 1'b1;
        #1;
        reset = 1'b0;
        apply_stimulus(L, L, L, '0, L);
        next_cycle();
        apply_stimulus(H, L, L, pack(32'h99), L);
        next_cycle();
        apply_stimulus(L, L, L, '0, L);
        repeat (5) next_cycle();
        apply_stimulus(L, H, L, '0, L);
        next_cycle();
        repeat (3) next_cycle();
        apply_stimulus(L, L, L, '0, L);
        check_word("stall_cnt",  stall_cnt,  32'd5);
        check_word("bubble_cnt", bubble_cnt, 32'd3);
        apply_stimulus(L, L, H, '0, L);
        next_cycle();
        apply_stimulus(L, L, L, '0, L);
        next_cycle();
        check_word("stall_cnt after flush",  stall_cnt,  32'd5);
        check_word("bubble_cnt after flush", bubble_cnt, 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
